// File: rtl/ipu_window_sequencer.sv
// ipu_window_sequencer: raster-walks a source image, builds padded 5x5
// windows, drives the convolution coprocessor and stores saturated results.
module ipu_window_sequencer #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       op_instruction,
  input  logic [199:0]      kernel,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_re,
  input  logic [7:0]        src_rdata,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_wdata,
  output logic              dst_we,
  output logic              ipu_request,
  output logic [31:0]       coproc_instruction,
  output logic              coproc_activate,
  input  logic              coproc_wait,
  input  logic              done_conv,
  input  logic [31:0]       matrix_C,
  output logic [199:0]      external_matrix_A,
  output logic [199:0]      external_matrix_B
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FULL,
    S_LOAD_COL,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        r_q, r_d;
  logic [2:0]        c_q, c_d;
  logic              pend_q, pend_d;
  logic              prd_q, prd_d;
  logic [4:0]        pidx_q, pidx_d;
  logic [199:0]      win_q, win_d;
  logic [199:0]      kern_q, kern_d;
  logic [31:0]       op_q, op_d;
  logic [31:0]       res_q, res_d;
  logic [ADDR_W-1:0] sb_q, sb_d;
  logic [ADDR_W-1:0] db_q, db_d;
  logic              err_q, err_d;

  logic [2:0]         col;
  logic signed [31:0] px;
  logic signed [31:0] py;
  logic               inb;
  logic               legal;
  logic [4:0]         slot;
  logic [ADDR_W-1:0]  raddr;
  logic [ADDR_W-1:0]  waddr;
  logic [31:0]        mag;
  logic [7:0]         sat;

  // Column loads always fill the rightmost window column.
  assign col = (state_q == S_LOAD_COL) ? 3'd4 : c_q;

  assign px = $signed({16'd0, x_q})
            + $signed({29'd0, col}) - 32'sd2;
  assign py = $signed({16'd0, y_q})
            + $signed({29'd0, r_q}) - 32'sd2;

  assign inb = (px >= 0) && (px < IMG_W)
            && (py >= 0) && (py < IMG_H);

  assign slot = {2'b00, r_q} * 5'd5 + {2'b00, col};

  assign raddr = ADDR_W'(32'(sb_q)
               + 32'(py * IMG_W) + 32'(px));
  assign waddr = ADDR_W'(32'(db_q)
               + 32'(y_q) * 32'(IMG_W) + 32'(x_q));

  // Magnitude of the signed result; 0x80000000 stays huge and clamps.
  assign mag = res_q[31] ? (~res_q + 32'd1) : res_q;
  assign sat = (mag > 32'd255) ? 8'hFF : mag[7:0];

  assign legal = (op_instruction[3:0] == 4'b0101)
              || (op_instruction[3:0] == 4'b0110)
              || (op_instruction[3:0] == 4'b0111);

  assign busy              = (state_q != S_IDLE);
  assign ipu_request       = busy;
  assign error             = err_q;
  assign external_matrix_A = win_q;
  assign external_matrix_B = kern_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      pend_q  <= 1'b0;
      prd_q   <= 1'b0;
      pidx_q  <= '0;
      win_q   <= '0;
      kern_q  <= '0;
      op_q    <= '0;
      res_q   <= '0;
      sb_q    <= '0;
      db_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      c_q     <= c_d;
      pend_q  <= pend_d;
      prd_q   <= prd_d;
      pidx_q  <= pidx_d;
      win_q   <= win_d;
      kern_q  <= kern_d;
      op_q    <= op_d;
      res_q   <= res_d;
      sb_q    <= sb_d;
      db_q    <= db_d;
      err_q   <= err_d;
    end
  end

  // Next-state, window assembly and port drive.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    c_d     = c_q;
    pend_d  = 1'b0;
    prd_d   = 1'b0;
    pidx_d  = pidx_q;
    win_d   = win_q;
    kern_d  = kern_q;
    op_d    = op_q;
    res_d   = res_q;
    sb_d    = sb_q;
    db_d    = db_q;
    err_d   = 1'b0;

    src_addr           = '0;
    src_re             = 1'b0;
    dst_addr           = '0;
    dst_wdata          = '0;
    dst_we             = 1'b0;
    coproc_instruction = '0;
    coproc_activate    = 1'b0;
    done               = 1'b0;

    // Slot issued last cycle lands now; padding slots land as zero.
    if (pend_q) begin
      win_d[8*pidx_q +: 8] = prd_q ? src_rdata : 8'd0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            op_d    = op_instruction;
            kern_d  = kernel;
            sb_d    = src_base;
            db_d    = dst_base;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            r_d     = '0;
            c_d     = '0;
            state_d = S_LOAD_FULL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_FULL: begin
        if (cnt_q == 5'd25) begin
          cnt_d   = '0;
          r_d     = '0;
          c_d     = '0;
          state_d = S_ISSUE;
        end else begin
          pend_d   = 1'b1;
          prd_d    = inb;
          pidx_d   = slot;
          src_re   = inb;
          src_addr = inb ? raddr : '0;
          cnt_d    = cnt_q + 5'd1;
          if (c_q == 3'd4) begin
            c_d = '0;
            r_d = r_q + 3'd1;
          end else begin
            c_d = c_q + 3'd1;
          end
        end
      end
      S_LOAD_COL: begin
        if (cnt_q == 5'd5) begin
          cnt_d   = '0;
          r_d     = '0;
          state_d = S_ISSUE;
        end else begin
          pend_d   = 1'b1;
          prd_d    = inb;
          pidx_d   = slot;
          src_re   = inb;
          src_addr = inb ? raddr : '0;
          cnt_d    = cnt_q + 5'd1;
          r_d      = r_q + 3'd1;
        end
      end
      S_ISSUE: begin
        if (!coproc_wait) begin
          coproc_activate    = 1'b1;
          coproc_instruction = op_q;
          state_d            = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_conv) begin
          res_d   = matrix_C;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        dst_we    = 1'b1;
        dst_addr  = waddr;
        dst_wdata = sat;
        if (x_q < 16'(IMG_W - 1)) begin
          x_d = x_q + 16'd1;
          for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
              win_d[8*(5*r+c) +: 8] =
                win_q[8*(5*r+c+1) +: 8];
            end
          end
          state_d = S_LOAD_COL;
        end else if (y_q < 16'(IMG_H - 1)) begin
          x_d     = '0;
          y_d     = y_q + 16'd1;
          state_d = S_LOAD_FULL;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ipu_window_sequencer.sv
// tb_ipu_window_sequencer: directed vectors and frame-level checks for
// the window sequencer on an 8x6 image with a behavioural coprocessor.
module tb_ipu_window_sequencer;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int AW   = 15;
  localparam int NPIX = W * H;
  localparam int NS   = 12;
  localparam int NOP  = 9;

  logic          clk;
  logic          reset;
  logic          start;
  logic [31:0]   op_instruction;
  logic [199:0]  kernel;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] src_addr;
  logic          src_re;
  logic [7:0]    src_rdata;
  logic [AW-1:0] dst_addr;
  logic [7:0]    dst_wdata;
  logic          dst_we;
  logic          ipu_request;
  logic [31:0]   coproc_instruction;
  logic          coproc_activate;
  logic          coproc_wait;
  logic          done_conv;
  logic [31:0]   matrix_C;
  logic [199:0]  external_matrix_A;
  logic [199:0]  external_matrix_B;

  ipu_window_sequencer #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .op_instruction    (op_instruction),
    .kernel            (kernel),
    .src_base          (src_base),
    .dst_base          (dst_base),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .src_addr          (src_addr),
    .src_re            (src_re),
    .src_rdata         (src_rdata),
    .dst_addr          (dst_addr),
    .dst_wdata         (dst_wdata),
    .dst_we            (dst_we),
    .ipu_request       (ipu_request),
    .coproc_instruction(coproc_instruction),
    .coproc_activate   (coproc_activate),
    .coproc_wait       (coproc_wait),
    .done_conv         (done_conv),
    .matrix_C          (matrix_C),
    .external_matrix_A (external_matrix_A),
    .external_matrix_B (external_matrix_B)
  );

  typedef struct {
    logic [31:0] c;
    logic [7:0]  q;
  } sat_t;

  typedef struct {
    logic [31:0] op;
    bit          legal;
  } op_t;

  sat_t sat_tab[NS];
  op_t  op_tab[NOP];

  logic [7:0] mem [0:32767];

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0;
  int rd_cnt = 0;
  int act_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int req_bad = 0;
  int ins_bad = 0;
  int act_wait = 0;
  int unstable = 0;
  int start_cyc = 0;
  int drop_cyc = 0;
  int done_cyc = 0;
  int last_busy_cyc = 0;
  int done_delay = 0;
  int mdly = 0;
  bit mpend = 0;
  bit in_conv = 0;
  logic prev_wait = 1'b0;
  logic [31:0]  cur_op = '0;
  logic [199:0] snap = '0;

  logic [199:0]  win_log[NPIX];
  int            act_cyc[NPIX];
  int            wr_cyc[NPIX];
  logic [AW-1:0] wa_log[NPIX];
  logic [7:0]    wd_log[NPIX];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source RAM, one-cycle read latency.
  initial forever begin
    @(posedge clk);
    if (src_re) src_rdata <= mem[src_addr];
  end

  // Negedge monitor plus behavioural coprocessor.
  initial forever begin
    @(negedge clk);
    if (start && !busy) begin
      start_cyc = cyc;
      rd_cnt    = 0;
      act_cnt   = 0;
      wr_cnt    = 0;
      done_cnt  = 0;
      unstable  = 0;
      act_wait  = 0;
      ins_bad   = 0;
    end
    if (reset) begin
      mpend   = 0;
      in_conv = 0;
    end
    if (prev_wait && !coproc_wait) drop_cyc = cyc;
    prev_wait = coproc_wait;
    if (ipu_request !== busy) req_bad++;
    if (busy) begin
      busy_cnt++;
      last_busy_cyc = cyc;
    end
    if (error) err_cnt++;
    if (src_re) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (in_conv && external_matrix_A !== snap) unstable++;
    if (dst_we) begin
      if (wr_cnt < NPIX) begin
        wa_log[wr_cnt] = dst_addr;
        wd_log[wr_cnt] = dst_wdata;
        wr_cyc[wr_cnt] = cyc;
      end
      wr_cnt++;
      in_conv = 0;
    end
    done_conv = 1'b0;
    if (mpend) begin
      if (mdly == 0) begin
        done_conv = 1'b1;
        matrix_C  = sat_tab[(act_cnt - 1) % NS].c;
        mpend     = 0;
      end else begin
        mdly--;
      end
    end
    if (coproc_activate) begin
      if (coproc_wait) act_wait++;
      if (coproc_instruction !== cur_op) ins_bad++;
      if (act_cnt < NPIX) begin
        win_log[act_cnt] = external_matrix_A;
        act_cyc[act_cnt] = cyc;
      end
      act_cnt++;
      snap    = external_matrix_A;
      in_conv = 1;
      mpend   = 1;
      mdly    = done_delay;
    end
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [199:0] act,
                     input logic [199:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] op,
                          input logic [199:0] k,
                          input logic [AW-1:0] sb,
                          input logic [AW-1:0] db);
    op_instruction = op;
    kernel         = k;
    src_base       = sb;
    dst_base       = db;
    start          = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_acts(input int n, input int lim);
    for (int k = 0; k < lim && act_cnt < n; k++) tick(1);
    chk("act_timeout", act_cnt >= n, 1);
  endtask

  task automatic wait_done(input int lim);
    for (int k = 0; k < lim && done_cnt == 0; k++) tick(1);
    chk("done_timeout", done_cnt > 0, 1);
    tick(3);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_ctl"},
        {busy, done, error, src_addr, src_re, dst_addr, dst_wdata,
         dst_we, ipu_request, coproc_instruction, coproc_activate}, 0);
    chk({nm, "_A"}, external_matrix_A, 0);
    chk({nm, "_B"}, external_matrix_B, 0);
  endtask

  function automatic logic [199:0] ref_win(input int idx, input int sb);
    logic [199:0] w;
    int x;
    int y;
    int px;
    int py;
    w = '0;
    x = idx % W;
    y = idx / W;
    for (int k = 0; k < 25; k++) begin
      px = x + (k % 5) - 2;
      py = y + (k / 5) - 2;
      if (px >= 0 && px < W && py >= 0 && py < H)
        w[8*k +: 8] = mem[(sb + py * W + px) % 32768];
    end
    return w;
  endfunction

  function automatic int ref_reads();
    int n;
    int x;
    int y;
    int px;
    int py;
    n = 0;
    for (int idx = 0; idx < NPIX; idx++) begin
      x = idx % W;
      y = idx / W;
      for (int k = 0; k < 25; k++) begin
        px = x + (k % 5) - 2;
        py = y + (k / 5) - 2;
        if ((x == 0 || (k % 5) == 4) &&
            px >= 0 && px < W && py >= 0 && py < H)
          n++;
      end
    end
    return n;
  endfunction

  initial begin
    logic [199:0] k1;
    logic [199:0] k2;
    logic [199:0] ecorner;
    int ks[9];
    int e0;
    int b0;
    int w0;
    int ebusy;

    sat_tab[0]  = '{32'hFFFF_FED4, 8'd255};
    sat_tab[1]  = '{32'hFFFF_FFF9, 8'd7};
    sat_tab[2]  = '{32'h0000_0000, 8'd0};
    sat_tab[3]  = '{32'h8000_0000, 8'd255};
    sat_tab[4]  = '{32'h0000_00FF, 8'd255};
    sat_tab[5]  = '{32'h0000_0100, 8'd255};
    sat_tab[6]  = '{32'hFFFF_FF01, 8'd255};
    sat_tab[7]  = '{32'h7FFF_FFFF, 8'd255};
    sat_tab[8]  = '{32'h0000_0001, 8'd1};
    sat_tab[9]  = '{32'hFFFF_FFFF, 8'd1};
    sat_tab[10] = '{32'h0000_0064, 8'd100};
    sat_tab[11] = '{32'hFFFF_FF00, 8'd255};

    op_tab[0] = '{32'h0000_0001, 1'b0};
    op_tab[1] = '{32'h0000_0005, 1'b1};
    op_tab[2] = '{32'h0000_0006, 1'b1};
    op_tab[3] = '{32'h0000_0007, 1'b1};
    op_tab[4] = '{32'hABCD_0007, 1'b1};
    op_tab[5] = '{32'h0000_0008, 1'b0};
    op_tab[6] = '{32'h0000_0004, 1'b0};
    op_tab[7] = '{32'h0000_0000, 1'b0};
    op_tab[8] = '{32'h0000_000F, 1'b0};

    ks = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    ecorner = '0;
    for (int i = 0; i < 9; i++) ecorner[8*ks[i] +: 8] = 8'd1;
    for (int i = 0; i < 25; i++) k1[8*i +: 8] = 8'(i + 1);
    for (int i = 0; i < 25; i++) k2[8*i +: 8] = 8'(8'hF0 - i);

    for (int a = 0; a < 32768; a++) mem[a] = 8'd0;

    reset          = 1'b1;
    start          = 1'b0;
    op_instruction = '0;
    kernel         = '0;
    src_base       = '0;
    dst_base       = '0;
    coproc_wait    = 1'b0;
    tick(2);
    chk_outs_zero("reset_state");
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < NOP; i++) begin
      e0 = err_cnt;
      b0 = busy_cnt;
      do_start(op_tab[i].op, k1, 15'd0, 15'd0);
      tick(3);
      chk($sformatf("op%0d_err", i), err_cnt - e0, !op_tab[i].legal);
      chk($sformatf("op%0d_busy", i), busy, op_tab[i].legal);
      if (!op_tab[i].legal) begin
        chk($sformatf("op%0d_nobusy", i), busy_cnt - b0, 0);
        chk($sformatf("op%0d_noread", i), rd_cnt, 0);
      end
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
    end

    for (int i = 0; i < NPIX; i++) mem[200 + i] = 8'd1;
    cur_op     = 32'h0000_0005;
    done_delay = 0;
    do_start(cur_op, k1, 15'd200, 15'd0);
    kernel = '0;
    wait_acts(1, 100);
    chk("corner_win", win_log[0], ecorner);
    chk("corner_reads", rd_cnt, 9);
    chk("corner_acts", act_cnt, 1);
    chk("full_load_lat", act_cyc[0] - start_cyc, 27);
    chk("kernel_latched", external_matrix_B, k1);
    wait_acts(2, 100);
    chk("col_load_lat", act_cyc[1] - act_cyc[0], 9);
    chk("col_reads", rd_cnt, 12);
    chk("first_wr_addr", wa_log[0], 0);
    chk("first_wr_data", wd_log[0], sat_tab[0].q);

    tick(3);
    b0 = busy_cnt;
    reset = 1'b1;
    tick(2);
    chk_outs_zero("midframe_reset");
    reset = 1'b0;
    w0 = wr_cnt;
    ebusy = busy_cnt;
    tick(20);
    chk("reset_no_write", wr_cnt - w0, 0);
    chk("reset_idle", busy_cnt - ebusy, 0);

    for (int a = 0; a < 32768; a++) mem[a] = 8'(a);
    cur_op     = 32'h1234_5676;
    done_delay = 0;
    do_start(cur_op, k2, 15'h7FF8, 15'h7FF0);
    wait_done(6000);
    chk("frame_writes", wr_cnt, NPIX);
    chk("frame_acts", act_cnt, NPIX);
    chk("frame_done_once", done_cnt, 1);
    chk("frame_reads", rd_cnt, ref_reads());
    chk("done_busy_fall", last_busy_cyc, done_cyc);
    chk("frame_instr", ins_bad, 0);
    chk("ipu_request_eq_busy", req_bad, 0);
    chk("frame_stable", unstable, 0);
    for (int i = 0; i < NPIX; i++) begin
      chk($sformatf("win_%0d", i), win_log[i], ref_win(i, 15'h7FF8));
      chk($sformatf("waddr_%0d", i), wa_log[i], AW'(15'h7FF0 + i));
      chk($sformatf("wdata_%0d", i), wd_log[i], sat_tab[i % NS].q);
    end

    cur_op      = 32'h0000_0006;
    done_delay  = 20;
    coproc_wait = 1'b1;
    do_start(cur_op, k2, 15'd300, 15'd1000);
    tick(40);
    chk("stall_deferred", act_cnt, 0);
    coproc_wait = 1'b0;
    wait_done(6000);
    chk("stall_act_at_drop", act_cyc[0], drop_cyc);
    chk("stall_wr_lat", wr_cyc[0] - act_cyc[0], 22);
    chk("stall_act_wait", act_wait, 0);
    chk("stall_stable", unstable, 0);
    chk("stall_acts", act_cnt, NPIX);
    chk("stall_writes", wr_cnt, NPIX);
    chk("stall_done_once", done_cnt, 1);
    chk("stall_win0", win_log[0], ref_win(0, 300));
    chk("stall_waddr_last", wa_log[NPIX-1], AW'(1000 + NPIX - 1));
    chk("stall_req", req_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ipu_window_sequencer.md
# ipu_window_sequencer

Image-processing sequencer that sits directly upstream of the convolution coprocessor. It walks a source image in raster order and builds a zero-padded 5x5 pixel window for every output pixel. It drives that window and a latched kernel onto the coprocessor's external operand ports, issues the convolution instruction with `ipu_request` asserted, and captures `matrix_C`. Each result is saturated to 8 bits and written to a destination image buffer.

## Interface
- `IMG_W`, 160, image width in pixels (>= 3)
- `IMG_H`, 120, image height in pixels (>= 3)
- `ADDR_W`, 15, pixel address width for the source and destination memories
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle start request. Accepted only in IDLE.
- `op_instruction` in 32: coprocessor instruction. `[3:0]` must be CONV 0101, CONV_TRSP 0110 or CONV_ROB 0111. Latched on start.
- `kernel` in 200: 5x5 signed-byte kernel. Latched on start.
- `src_base`, `dst_base` in ADDR_W: image base addresses. Latched on start.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last pixel is written.
- `error` out 1: one-cycle pulse when start carries an illegal opcode.
- `src_addr` out ADDR_W, `src_re` out 1, `src_rdata` in 8: source RAM read port with 1-cycle read latency.
- `dst_addr` out ADDR_W, `dst_wdata` out 8, `dst_we` out 1: destination RAM write port.
- `ipu_request` out 1: operand-mux select to the coprocessor. Equal to `busy`.
- `coproc_instruction` out 32, `coproc_activate` out 1: instruction issue to the coprocessor.
- `coproc_wait` in 1: coprocessor busy flag.
- `done_conv` in 1: convolution complete.
- `matrix_C` in 32: convolution result, signed.
- `external_matrix_A` out 200: current window.
- `external_matrix_B` out 200: latched kernel.

## Operation
- Window packing: byte k = row*5 + col occupies bits [8k+7:8k]. Row 0 is y-2 and col 0 is x-2 for center (x,y).
- A pixel at (px,py) outside 0..IMG_W-1 / 0..IMG_H-1 is padding: value 0, no read issued, slot still consumed.
- In-bounds read address: `src_base + py*IMG_W + px`. Write address: `dst_base + y*IMG_W + x`. Both wrap modulo 2^ADDR_W.
- **IDLE**
  - On start with a legal opcode: latch all inputs, set x=y=0, go to LOAD_FULL.
  - On start with an illegal opcode: pulse `error`, stay in IDLE.
- **LOAD_FULL** (x==0):
  - 25 slots in row-major order, one per cycle.
  - `src_re`=1 only for in-bounds slots.
  - Data is written into its byte one cycle after issue.
- **LOAD_COL** (x>0):
  - Shift the window left one column (col c takes col c+1).
  - Load the new col 4 (px = x+2, rows y-2..y+2) in 5 slots.
- **ISSUE**
  - When `coproc_wait`=0: drive `coproc_instruction`=latched op with `coproc_activate`=1 for exactly one cycle, then go to WAIT.
  - Otherwise hold in ISSUE.
- **WAIT**
  - Stay until `done_conv`=1; capture `matrix_C` on that cycle.
- **WRITE**
  - `dst_we`=1 for one cycle.
  - `dst_wdata` = min(|matrix_C|, 255), with |matrix_C| taken as a 32-bit signed magnitude and 0x80000000 mapped to 255.
- **Advance**
  - If x<IMG_W-1: x+1, go to LOAD_COL.
  - Else if y<IMG_H-1: x=0, y+1, go to LOAD_FULL.
  - Else go to FINISH.
- **FINISH**: pulse `done`, return to IDLE.
- `start` while busy is ignored.
- Latched op, kernel and bases are stable for the whole frame.

## Timing
- Reset values: every output 0; both matrices 0; FSM in IDLE. Reset mid-frame reaches IDLE on the next edge with no further `dst_we`.
- Load latency:
  - LOAD_FULL: 26 cycles (25 issue slots + 1 last-data cycle).
  - LOAD_COL: 6 cycles.
- `external_matrix_A` is complete and stable from ISSUE entry until WRITE exit.
- `coproc_activate` is asserted only in the ISSUE cycle that exits; it is never asserted twice per pixel.
- `ipu_request`=1 continuously from the cycle after an accepted start through the FINISH cycle.
- `done` and `busy` fall in the same edge; the FSM is back in IDLE one cycle after FINISH.
- Minimum pixel period excluding WAIT: 26 + 1 + 1 cycles at x=0; 6 + 1 + 1 otherwise.

## Test plan
- **Reset**: assert reset for 2 cycles while mid-frame -> next cycle every output is 0, `busy`=0, and no `dst_we` follows.
- **Illegal opcode**: start with op 0x00000001 -> `error`=1 for exactly one cycle, `busy` stays 0, `src_re` is never asserted.
- **Corner window**: IMG_W=8, IMG_H=6, all pixels 1, op CONV.
  - Pixel (0,0): bytes 12,13,14,17,18,19,22,23,24 = 1 and all others 0.
  - Exactly 9 reads are issued.
  - `coproc_activate` pulses once.
- **Saturation**: model returns `matrix_C` of -300, -7, 0, 0x80000000 -> `dst_wdata` is 255, 7, 0, 255.
- **Full frame**: 8x6 image with pixel value = address & 0xFF.
  - 48 writes at `dst_base`..`dst_base`+47 in raster order.
  - Each window checked against a reference model.
  - `done` pulses once.
- **Handshake stall**: hold `coproc_wait`=1 for 10 cycles at ISSUE, and delay `done_conv` by 20 cycles -> activate is deferred until wait drops, window stays stable, and exactly one write per pixel.
